// File: rtl/axi_mem_responder_pkg.sv
// rtl/axi_mem_responder_pkg.sv - shared types and constants for the AXI4 memory responder
package axi_mem_responder_pkg;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_BURST}        rd_state_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int calc_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// rtl/axi_mem_responder_ram.sv - word array with byte-enable write and registered read-before-write port
module axi_mem_responder_ram #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10,
    parameter int STRB_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Non-blocking update means a colliding read sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave memory model; RESPONDER_BACKPRESSURE_EN adds LFSR-driven stalls
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH        = 1024
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic                            proto_err
);

    localparam int LSB    = calc_lsb(C_S_AXI_DATA_WIDTH);
    localparam int IDX_W  = $clog2(C_MEM_DEPTH);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic stall_w, stall_r;
`ifdef RESPONDER_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
    end
    assign stall_w     = lfsr_q[0];
    assign stall_r     = lfsr_q[1];
    assign unused_lfsr = ^lfsr_q[15:2];
`else
    assign stall_w = 1'b0;
    assign stall_r = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    wr_state_t        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]       wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
    logic             awready_q, awready_d, bvalid_q, bvalid_d, perr_q, perr_d;
    logic             wr_beat;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_len_d   = wr_len_q;
        wr_cnt_d   = wr_cnt_q;
        perr_d     = perr_q;
        wr_beat    = 1'b0;
        case (wr_state_q)
            W_IDLE: if (s_axi_awvalid && awready_q) begin
                wr_idx_d   = s_axi_awaddr[LSB +: IDX_W];
                wr_len_d   = s_axi_awlen;
                wr_cnt_d   = '0;
                wr_state_d = W_DATA;
            end
            W_DATA: if (s_axi_wvalid && !stall_w) begin
                wr_beat  = 1'b1;
                wr_idx_d = wr_idx_q + 1'b1;
                wr_cnt_d = wr_cnt_q + 8'd1;
                // Burst length comes from awlen; wlast is only cross-checked.
                if (s_axi_wlast != (wr_cnt_q == wr_len_q)) perr_d = 1'b1;
                if (wr_cnt_q == wr_len_q) wr_state_d = W_RESP;
            end
            W_RESP: if (s_axi_bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
        awready_d = (wr_state_d == W_IDLE);
        bvalid_d  = (wr_state_d == W_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_len_q   <= wr_len_d;
            wr_cnt_q   <= wr_cnt_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            perr_q     <= perr_d;
        end
    end

    rd_state_t        rd_state_q, rd_state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       rd_len_q, rd_len_d;
    logic [8:0]       rd_cnt_q, rd_cnt_d;
    logic             arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic             rd_load;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rd_load    = 1'b0;
        case (rd_state_q)
            R_IDLE: if (s_axi_arvalid && arready_q) begin
                rd_idx_d   = s_axi_araddr[LSB +: IDX_W];
                rd_len_d   = s_axi_arlen;
                rd_cnt_d   = '0;
                rd_state_d = R_BURST;
            end
            R_BURST: begin
                if (rvalid_q && s_axi_rready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rlast_d    = 1'b0;
                        rd_state_d = R_IDLE;
                    end
                end
                // Output slot free and beats still owed: fetch the next word.
                if ((!rvalid_q || s_axi_rready) && (rd_cnt_q <= {1'b0, rd_len_q}) && !stall_r) begin
                    rd_load  = 1'b1;
                    rvalid_d = 1'b1;
                    rlast_d  = (rd_cnt_q[7:0] == rd_len_q);
                    rd_cnt_d = rd_cnt_q + 9'd1;
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_len_q   <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
        end
    end

    axi_mem_responder_ram #(
        .DATA_W (C_S_AXI_DATA_WIDTH),
        .DEPTH  (C_MEM_DEPTH),
        .IDX_W  (IDX_W),
        .STRB_W (STRB_W)
    ) u_ram (
        .clk   (aclk),
        .rst_n (aresetn),
        .we    (wr_beat),
        .waddr (wr_idx_q),
        .wdata (s_axi_wdata),
        .wstrb (s_axi_wstrb),
        .re    (rd_load),
        .raddr (rd_idx_q),
        .rdata (s_axi_rdata)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = (wr_state_q == W_DATA) && !stall_w;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign proto_err     = perr_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - scoreboard bench for axi_mem_responder
module tb_axi_mem_responder;

    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1024;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_axi_awvalid, s_axi_awready;
    logic [AW-1:0] s_axi_awaddr;
    logic [7:0]    s_axi_awlen;
    logic          s_axi_wvalid, s_axi_wready;
    logic [DW-1:0] s_axi_wdata;
    logic [SW-1:0] s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_bvalid, s_axi_bready;
    logic          s_axi_arvalid, s_axi_arready;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic          s_axi_rvalid, s_axi_rready;
    logic [DW-1:0] s_axi_rdata;
    logic          s_axi_rlast;
    logic          proto_err;

    axi_mem_responder dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rlast   (s_axi_rlast),
        .proto_err     (proto_err)
    );

    always #5 aclk = ~aclk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] wbuf [16];
    logic [SW-1:0] sbuf [16];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input int len, input int bad_last);
        int n;
        int idx;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 50) begin @(posedge aclk); #1; n++; end
        check("aw_timeout", DW'(n < 50), DW'(1));
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            s_axi_wdata  = wbuf[i];
            s_axi_wstrb  = sbuf[i];
            s_axi_wlast  = (i == len) != (i == bad_last);
            s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < 50) begin @(posedge aclk); #1; n++; end
            check("w_timeout", DW'(n < 50), DW'(1));
            if (i < len) check("bvalid_early", DW'(s_axi_bvalid), DW'(0));
            @(posedge aclk); #1;
            idx = (int'(addr[6 +: 10]) + i) % DEPTH;
            for (int b = 0; b < SW; b++)
                if (sbuf[i][b]) model[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        check("bvalid_lat", DW'(s_axi_bvalid), DW'(1));
        check("wready_resp", DW'(s_axi_wready), DW'(0));
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
        check("bvalid_clr", DW'(s_axi_bvalid), DW'(0));
        check("awready_back", DW'(s_axi_awready), DW'(1));
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input int stall_beat, input int abort_at);
        int            n;
        int            got;
        int            cyc;
        logic [DW-1:0] hold;
        logic          hold_last;
        for (int i = 0; i <= len; i++)
            exp_q.push_back(model[(int'(addr[6 +: 10]) + i) % DEPTH]);
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin @(posedge aclk); #1; n++; end
        check("ar_timeout", DW'(n < 50), DW'(1));
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        check("arready_drop", DW'(s_axi_arready), DW'(0));
        check("rvalid_n1", DW'(s_axi_rvalid), DW'(0));
        @(posedge aclk); #1;
        check("r_first_lat", DW'(s_axi_rvalid), DW'(1));
        got = 0;
        cyc = 0;
        while (got <= len && cyc < 300) begin
            if (got == abort_at) return;
            if (s_axi_rvalid) begin
                if (got == stall_beat) begin
                    hold         = s_axi_rdata;
                    hold_last    = s_axi_rlast;
                    s_axi_rready = 1'b0;
                    repeat (5) begin
                        @(posedge aclk); #1;
                        check("stall_rvalid", DW'(s_axi_rvalid), DW'(1));
                        check("stall_rdata", s_axi_rdata, hold);
                        check("stall_rlast", DW'(s_axi_rlast), DW'(hold_last));
                        check("stall_arready", DW'(s_axi_arready), DW'(0));
                    end
                    s_axi_rready = 1'b1;
                end
                check("rdata", s_axi_rdata, exp_q.pop_front());
                check("rlast", DW'(s_axi_rlast), DW'(got == len));
                got++;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        check("r_timeout", DW'(cyc < 300), DW'(1));
        check("rvalid_end", DW'(s_axi_rvalid), DW'(0));
        check("arready_end", DW'(s_axi_arready), DW'(1));
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
        s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_rready  = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", DW'(s_axi_awready), DW'(0));
        check("rst_arready", DW'(s_axi_arready), DW'(0));
        check("rst_wready", DW'(s_axi_wready), DW'(0));
        check("rst_bvalid", DW'(s_axi_bvalid), DW'(0));
        check("rst_rvalid", DW'(s_axi_rvalid), DW'(0));
        check("rst_rlast", DW'(s_axi_rlast), DW'(0));
        check("rst_rdata", s_axi_rdata, '0);
        check("rst_proto_err", DW'(proto_err), DW'(0));
        aresetn = 1'b1;
        #1;
        check("rel_awready0", DW'(s_axi_awready), DW'(0));
        @(posedge aclk); #1;
        check("rel_awready1", DW'(s_axi_awready), DW'(1));
        check("rel_arready1", DW'(s_axi_arready), DW'(1));

        // Four-beat write/read at address 0
        for (int i = 0; i < 4; i++) begin wbuf[i] = DW'(32'hA0 + i); sbuf[i] = '1; end
        wr_burst(64'h0, 3, -1);
        rd_burst(64'h0, 3, -1, -1);
        check("proto_err_clean", DW'(proto_err), DW'(0));

        // Partial strobe over an all-ones word
        wbuf[0] = '1; sbuf[0] = '1;
        wr_burst(64'd10 * 64, 0, -1);
        wbuf[0] = '0; sbuf[0] = SW'(64'h0000_0000_0000_00FF);
        wr_burst(64'd10 * 64, 0, -1);
        check("strb_model", model[10], {{(SW-8){8'hFF}}, 64'h0});
        rd_burst(64'd10 * 64, 0, -1, -1);

        // Wrap from index 1022; high and low address bits are ignored
        for (int i = 0; i < 4; i++) begin wbuf[i] = {16{$urandom()}}; sbuf[i] = '1; end
        wr_burst(64'hFFFF_0000_0000_0000 | (64'd1022 * 64) | 64'h5, 3, -1);
        rd_burst(64'h0, 1, -1, -1);
        rd_burst(64'd1022 * 64, 3, 1, -1);

        // Early wlast marks a protocol error but the burst still runs to awlen
        for (int i = 0; i < 4; i++) begin wbuf[i] = {16{$urandom()}}; sbuf[i] = '1; end
        wr_burst(64'd100 * 64, 3, 1);
        check("proto_err_set", DW'(proto_err), DW'(1));
        for (int i = 0; i < 2; i++) begin wbuf[i] = {16{$urandom()}}; sbuf[i] = {2{$urandom()}}; end
        wr_burst(64'd200 * 64, 1, -1);
        check("proto_err_sticky", DW'(proto_err), DW'(1));
        rd_burst(64'd100 * 64, 3, -1, -1);
        rd_burst(64'd200 * 64, 1, 0, -1);

        // Reset in the middle of a read burst
        rd_burst(64'd100 * 64, 7, -1, 2);
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_rvalid", DW'(s_axi_rvalid), DW'(0));
        check("mid_rst_arready", DW'(s_axi_arready), DW'(0));
        check("mid_rst_proto_err", DW'(proto_err), DW'(0));
        @(posedge aclk); #2;
        aresetn = 1'b1;
        #1;
        check("post_rst_arready0", DW'(s_axi_arready), DW'(0));
        @(posedge aclk); #1;
        check("post_rst_arready1", DW'(s_axi_arready), DW'(1));
        rd_burst(64'd100 * 64, 3, 2, -1);
        check("post_rst_q_empty", DW'(exp_q.size()), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
